// File: rtl/rs232_pkg.sv
// Shared constants and FSM state types for the RS-232 Avalon slave.
package rs232_pkg;

    localparam logic [4:0] ADDR_RX     = 5'd0;
    localparam logic [4:0] ADDR_TX     = 5'd4;
    localparam logic [4:0] ADDR_STATUS = 5'd8;

    localparam int unsigned ST_RX_OK      = 7;
    localparam int unsigned ST_TX_OK      = 6;
    localparam int unsigned ST_FRAME_ERR  = 2;
    localparam int unsigned ST_TX_DROP    = 1;
    localparam int unsigned ST_RX_OVERRUN = 0;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

endpackage

// File: rtl/rs232_rx_frame.sv
// 8N1 deserializer: 2-FF synchronizer, falling-edge start detect, mid-bit sampling.
module rs232_rx_frame
    import rs232_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);

    rx_state_t     state;
    logic [1:0]    sync;
    logic          rxd_d;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= '1;
            rxd_d     <= 1'b1;
            state     <= R_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[0], rxd};
            rxd_d     <= sync[1];
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                R_IDLE: begin
                    if (rxd_d && !sync[1]) begin
                        state <= R_START;
                        cnt   <= '0;
                    end
                end
                R_START: begin
                    if (cnt == MID) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= sync[1] ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shift <= {sync[1], shift[7:1]};
                        if (bit_cnt == 3'd7) state <= R_STOP;
                        else bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= R_IDLE;
                        if (sync[1]) begin
                            data  <= shift;
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rs232_avalon_slave.sv
// Avalon-MM UART slave (RX/TX/STATUS), one wait state per access.
// Define RS232_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register.
module rs232_avalon_slave
    import rs232_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [7:0]  rx_byte;
    logic        rx_valid, rx_ferr;
    logic        ack, pop_pending, pop, push_ok;
    logic        rx_ok, rx_full;
    logic [7:0]  rx_head;
    logic        access, rd_done, tx_hit, status_clr;
    logic        frame_err_f, tx_drop_f, overrun_f;
    logic [31:0] read_mux;
    logic        unused_wdata;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_pending, tx_ok;

    rs232_rx_frame #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (avm_clk),
        .rst       (avm_rst),
        .rxd       (uart_rxd),
        .data      (rx_byte),
        .valid     (rx_valid),
        .frame_err (rx_ferr)
    );

    assign unused_wdata    = ^avs_writedata[31:8];
    assign access          = avs_read | avs_write;
    assign avs_waitrequest = ~ack;
    assign rd_done         = ack & avs_read;
    assign tx_hit          = ack & avs_write & ~avs_read & (avs_address == ADDR_TX);
    assign status_clr      = rd_done & (avs_address == ADDR_STATUS);
    assign pop             = ack & pop_pending;
    assign push_ok         = rx_valid & (~rx_full | pop);
    assign tx_ok           = (tx_state == T_IDLE) & ~tx_pending;

`ifdef RS232_RX_FIFO_EN
    logic [7:0] fifo [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;

    assign rx_ok   = (count != 3'd0);
    assign rx_full = (count == 3'd4);
    assign rx_head = fifo[rd_ptr];

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge avm_clk) begin
        if (push_ok) fifo[wr_ptr] <= rx_byte;
    end
`else
    logic [7:0] hold;
    logic       full;

    assign rx_ok   = full;
    assign rx_full = full;
    assign rx_head = hold;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            hold <= '0;
            full <= 1'b0;
        end else if (push_ok) begin
            hold <= rx_byte;
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end
`endif

    always_comb begin
        read_mux = '0;
        if (avs_read) begin
            case (avs_address)
                ADDR_RX:     if (rx_ok) read_mux = {24'b0, rx_head};
                ADDR_STATUS: begin
                    read_mux[ST_RX_OK]      = rx_ok;
                    read_mux[ST_TX_OK]      = tx_ok;
                    read_mux[ST_FRAME_ERR]  = frame_err_f;
                    read_mux[ST_TX_DROP]    = tx_drop_f;
                    read_mux[ST_RX_OVERRUN] = overrun_f;
                end
                default: read_mux = '0;
            endcase
        end
    end

    // Read data is captured in the first cycle; the pop decision is latched with it
    // so an empty-buffer read never pops a byte that arrived during the wait state.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            ack          <= 1'b0;
            pop_pending  <= 1'b0;
            avs_readdata <= '0;
            frame_err_f  <= 1'b0;
            tx_drop_f    <= 1'b0;
            overrun_f    <= 1'b0;
        end else begin
            ack <= access & ~ack;
            if (access && !ack) begin
                avs_readdata <= read_mux;
                pop_pending  <= avs_read & (avs_address == ADDR_RX) & rx_ok;
            end else if (ack) begin
                pop_pending <= 1'b0;
            end
            frame_err_f <= rx_ferr | (frame_err_f & ~status_clr);
            tx_drop_f   <= (tx_hit & ~tx_ok) | (tx_drop_f & ~status_clr);
            overrun_f   <= (rx_valid & ~push_ok) | (overrun_f & ~status_clr);
        end
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            tx_state   <= T_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            tx_pending <= 1'b0;
            uart_txd   <= 1'b1;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (tx_pending) begin
                        tx_state   <= T_START;
                        tx_cnt     <= '0;
                        tx_pending <= 1'b0;
                        uart_txd   <= 1'b0;
                    end
                end
                T_START: begin
                    if (tx_cnt == LAST) begin
                        tx_state <= T_DATA;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_txd <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                T_DATA: begin
                    if (tx_cnt == LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= T_STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            uart_txd <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                T_STOP: begin
                    if (tx_cnt == LAST) begin
                        tx_state <= T_IDLE;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
            if (tx_hit && tx_ok) begin
                tx_pending <= 1'b1;
                tx_shift   <= avs_writedata[7:0];
            end
        end
    end

endmodule

// File: tb/tb_rs232_avalon_slave.sv
// Directed bench for rs232_avalon_slave with CLKS_PER_BIT=4.
module tb_rs232_avalon_slave;

    localparam int unsigned CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;

    int checks = 0;
    int errors = 0;
    logic [2:0] ws;

    always #5 clk = ~clk;

    rs232_avalon_slave #(.CLKS_PER_BIT(CPB)) dut (
        .avm_clk         (clk),
        .avm_rst         (rst),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_waitrequest (avs_waitrequest),
        .uart_rxd        (uart_rxd),
        .uart_txd        (uart_txd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Tasks are entered and left 1 time unit after a rising edge.
    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        ws[2]       = avs_waitrequest;
        idle(1);
        ws[1]       = avs_waitrequest;
        d           = avs_readdata;
        idle(1);
        avs_read    = 1'b0;
        ws[0]       = avs_waitrequest;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] wd);
        avs_address   = a;
        avs_writedata = wd;
        avs_write     = 1'b1;
        ws[2]         = avs_waitrequest;
        idle(1);
        ws[1]         = avs_waitrequest;
        idle(1);
        avs_write     = 1'b0;
        ws[0]         = avs_waitrequest;
    endtask

    task automatic read_check(input logic [4:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            idle(CPB);
        end
        uart_rxd = stop;
        idle(CPB);
        uart_rxd = 1'b1;
        idle(6);
    endtask

    initial begin
        logic [31:0] d;
        logic [39:0] tx_line;
        logic [9:0]  frame;
        logic        seen_low;

        idle(3);
        check("rst_txd", uart_txd, 1);
        check("rst_wait", avs_waitrequest, 1);
        check("rst_rdata", avs_readdata, 0);
        rst = 1'b0;
        idle(2);
        check("idle_txd", uart_txd, 1);
        check("idle_wait", avs_waitrequest, 1);
        bus_read(5'd8, d);
        check("status_reset", d, 32'h40);
        check("read_wait_pattern", ws, 3'b101);

        send_byte(8'hA5, 1'b1);
        read_check(5'd8, 32'h0000_00C0, "status_rx_ok");
        read_check(5'd0, 32'h0000_00A5, "rx_a5");
        read_check(5'd8, 32'h0000_0040, "status_after_pop");
        read_check(5'd0, 32'h0, "rx_empty");

        read_check(5'd12, 32'h0, "unmapped_read");
        check("unmapped_read_wait", ws, 3'b101);
        bus_write(5'd12, 32'h99);
        check("unmapped_write_wait", ws, 3'b101);
        avs_write = 1'b1;
        read_check(5'd4, 32'h0, "rd_wr_as_read");
        avs_write = 1'b0;
        idle(3);
        check("rd_wr_no_tx", uart_txd, 1);
        read_check(5'd8, 32'h40, "status_after_rw");

        bus_write(5'd4, 32'hFFFF_FF3C);
        check("tx_write_wait", ws, 3'b101);
        check("tx_idle_at_completion", uart_txd, 1);
        for (int c = 0; c < 40; c++) begin
            idle(1);
            tx_line[c] = uart_txd;
        end
        frame = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 10; i++)
            check($sformatf("tx_bit%0d", i), tx_line[4*i +: 4], {4{frame[i]}});
        read_check(5'd8, 32'h00, "status_tx_stop_end");
        read_check(5'd8, 32'h40, "status_tx_done");

        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
`ifdef RS232_RX_FIFO_EN
        read_check(5'd0, 32'h11, "fifo_rx_11");
        read_check(5'd0, 32'h22, "fifo_rx_22");
        read_check(5'd8, 32'h40, "fifo_status_empty");
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        read_check(5'd8, 32'hC1, "fifo_status_overrun");
        read_check(5'd0, 32'h01, "fifo_rx_oldest");
        for (int i = 2; i <= 4; i++) read_check(5'd0, 32'(i), "fifo_rx_drain");
        read_check(5'd8, 32'h40, "fifo_status_drained");
`else
        read_check(5'd0, 32'h11, "rx_keeps_older");
        read_check(5'd8, 32'h41, "status_overrun");
        read_check(5'd8, 32'h40, "status_overrun_cleared");
`endif

        send_byte(8'h55, 1'b0);
        read_check(5'd8, 32'h44, "status_frame_err");
        read_check(5'd8, 32'h40, "status_frame_err_cleared");
        read_check(5'd0, 32'h0, "rx_frame_err_discarded");

        bus_write(5'd4, 32'h00);
        bus_write(5'd4, 32'h77);
        read_check(5'd8, 32'h02, "status_tx_drop");
        read_check(5'd8, 32'h00, "status_tx_busy");
        check("tx_mid_frame_low", uart_txd, 0);
        rst = 1'b1;
        #1;
        check("tx_async_abort", uart_txd, 1);
        check("rst_async_wait", avs_waitrequest, 1);
        idle(2);
        rst = 1'b0;
        idle(1);
        read_check(5'd8, 32'h40, "status_after_abort");
        seen_low = 1'b0;
        for (int c = 0; c < 40; c++) begin
            idle(1);
            if (uart_txd == 1'b0) seen_low = 1'b1;
        end
        check("tx_stays_idle", seen_low, 0);

        fork
            send_byte(8'hFF, 1'b1);
            begin
                idle(14);
                rst = 1'b1;
                idle(2);
                rst = 1'b0;
            end
        join
        read_check(5'd8, 32'h40, "status_rx_partial_lost");
        read_check(5'd0, 32'h0, "rx_partial_lost");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
